// File: rtl/hazard_pkg.sv
// Shared definitions for the load hazard scoreboard: opcodes, FSM states and
// the pending-load table entry.
package hazard_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Entry rd field is sized for the widest supported register index;
    // narrower indices are zero-extended on the way in.
    localparam int unsigned ENTRY_RD_W = 8;

    typedef enum logic [1:0] {
        HZ_RUN,
        HZ_STALL,
        HZ_ERR
    } hz_state_e;

    typedef struct packed {
        logic                  valid;
        logic [ENTRY_RD_W-1:0] rd;
    } pend_entry_t;

endpackage

// File: rtl/hazard_src_decode.sv
// Combinational RV32I field extraction: which sources an instruction reads,
// whether it is a load, and its register indices.
module hazard_src_decode
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [31:0]       inst,
    output logic              use_rs1,
    output logic              use_rs2,
    output logic              is_load,
    output logic [REG_AW-1:0] rs1,
    output logic [REG_AW-1:0] rs2,
    output logic [REG_AW-1:0] rd
);

    logic unused_inst_bits;
    assign unused_inst_bits = ^{inst[31:25], inst[14:12]};

    assign rs1 = REG_AW'(inst[19:15]);
    assign rs2 = REG_AW'(inst[24:20]);
    assign rd  = REG_AW'(inst[11:7]);

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        is_load = 1'b0;
        case (inst[6:0])
            OPC_OP, OPC_STORE, OPC_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_OPIMM, OPC_JALR: begin
                use_rs1 = 1'b1;
            end
            OPC_LOAD: begin
                use_rs1 = 1'b1;
                is_load = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_hazard_scoreboard.sv
// Outstanding-load scoreboard: stalls decode on RAW/WAW against pending loads or a full
// table, with stall-timeout detection. Define HAZARD_STATS_EN for stall statistics.
module load_hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_PENDING = 2,
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned TIMEOUT     = 64,
    parameter int unsigned CNT_W       = $clog2(TIMEOUT + 1)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               dec_valid,
    input  logic [31:0]                        dec_inst,
    input  logic                               wb_valid,
    input  logic [REG_AW-1:0]                  wb_rd,
    input  logic                               flush,
    output logic                               stall,
    output logic [$clog2(NUM_PENDING+1)-1:0]   pending_cnt,
`ifdef HAZARD_STATS_EN
    output logic [31:0]                        stat_stall_cycles,
    output logic [31:0]                        stat_raw_stalls,
`endif
    output logic                               timeout_err
);

    localparam int unsigned PC_W = $clog2(NUM_PENDING + 1);

    logic              use_rs1, use_rs2, is_load;
    logic [REG_AW-1:0] rs1, rs2, rd;

    hazard_src_decode #(
        .REG_AW (REG_AW)
    ) u_src_decode (
        .inst    (dec_inst),
        .use_rs1 (use_rs1),
        .use_rs2 (use_rs2),
        .is_load (is_load),
        .rs1     (rs1),
        .rs2     (rs2),
        .rd      (rd)
    );

    pend_entry_t entries_q [NUM_PENDING];
    pend_entry_t entries_d [NUM_PENDING];
    hz_state_e   state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PC_W-1:0]  pending_cnt_d;

    logic hit_rs1, hit_rs2, hit_rd;
    logic ld_tracked, cond_raw, cond_waw, cond_full;
    logic alloc_en, enter_err, clear_all, found;

    // Hits use the registered table only: a writeback this cycle does not bypass.
    always_comb begin
        hit_rs1 = 1'b0;
        hit_rs2 = 1'b0;
        hit_rd  = 1'b0;
        for (int i = 0; i < NUM_PENDING; i++) begin
            if (entries_q[i].valid) begin
                if (entries_q[i].rd == ENTRY_RD_W'(rs1)) hit_rs1 = 1'b1;
                if (entries_q[i].rd == ENTRY_RD_W'(rs2)) hit_rs2 = 1'b1;
                if (entries_q[i].rd == ENTRY_RD_W'(rd))  hit_rd  = 1'b1;
            end
        end
    end

    assign ld_tracked = is_load && (rd != '0);
    assign cond_raw   = (use_rs1 && (rs1 != '0) && hit_rs1) ||
                        (use_rs2 && (rs2 != '0) && hit_rs2);
    assign cond_waw   = ld_tracked && hit_rd;
    assign cond_full  = ld_tracked && (pending_cnt == PC_W'(NUM_PENDING));

    assign stall = rst_n && dec_valid && !flush && (state_q != HZ_ERR) &&
                   (cond_raw || cond_waw || cond_full);

    assign alloc_en = rst_n && dec_valid && ld_tracked && !stall && !flush;

    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        enter_err   = 1'b0;
        unique case (state_q)
            HZ_RUN: begin
                if (stall) begin
                    state_d     = HZ_STALL;
                    stall_cnt_d = CNT_W'(1);
                end else begin
                    stall_cnt_d = '0;
                end
            end
            HZ_STALL: begin
                if (!stall) begin
                    state_d     = HZ_RUN;
                    stall_cnt_d = '0;
                end else if (stall_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = HZ_ERR;
                    enter_err = 1'b1;
                end else if (stall_cnt_q != '1) begin
                    stall_cnt_d = stall_cnt_q + CNT_W'(1);
                end
            end
            HZ_ERR: begin
                state_d     = HZ_RUN;
                stall_cnt_d = '0;
            end
            default: begin
                state_d     = HZ_RUN;
                stall_cnt_d = '0;
            end
        endcase
        if (flush) stall_cnt_d = '0;
    end

    assign clear_all = flush || enter_err || (state_q == HZ_ERR);

    // Clear first, then allocate from the registered free map, so a slot freed
    // this cycle is not reused until the next one.
    always_comb begin
        found = 1'b0;
        for (int i = 0; i < NUM_PENDING; i++) begin
            entries_d[i] = entries_q[i];
            if (wb_valid && entries_q[i].valid && (entries_q[i].rd == ENTRY_RD_W'(wb_rd))) begin
                entries_d[i].valid = 1'b0;
            end
        end
        if (alloc_en) begin
            for (int i = 0; i < NUM_PENDING; i++) begin
                if (!found && !entries_q[i].valid) begin
                    entries_d[i].valid = 1'b1;
                    entries_d[i].rd    = ENTRY_RD_W'(rd);
                    found              = 1'b1;
                end
            end
        end
        if (clear_all) begin
            for (int i = 0; i < NUM_PENDING; i++) entries_d[i] = '0;
        end
    end

    always_comb begin
        pending_cnt_d = '0;
        for (int i = 0; i < NUM_PENDING; i++) begin
            pending_cnt_d = pending_cnt_d + PC_W'(entries_d[i].valid);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= HZ_RUN;
            stall_cnt_q <= '0;
            pending_cnt <= '0;
            timeout_err <= 1'b0;
            for (int i = 0; i < NUM_PENDING; i++) entries_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            pending_cnt <= pending_cnt_d;
            timeout_err <= timeout_err || enter_err;
            for (int i = 0; i < NUM_PENDING; i++) entries_q[i] <= entries_d[i];
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_stall_cycles <= '0;
            stat_raw_stalls   <= '0;
        end else begin
            if (stall) stat_stall_cycles <= stat_stall_cycles + 32'd1;
            if (stall && (state_q == HZ_RUN) && cond_raw) begin
                stat_raw_stalls <= stat_raw_stalls + 32'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_load_hazard_scoreboard.sv
// Directed, table-driven bench for load_hazard_scoreboard (NUM_PENDING=2, TIMEOUT=8).
module tb_load_hazard_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        dec_valid;
    logic [31:0] dec_inst;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        stall;
    logic [1:0]  pending_cnt;
    logic        timeout_err;
`ifdef HAZARD_STATS_EN
    logic [31:0] stat_stall_cycles;
    logic [31:0] stat_raw_stalls;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    load_hazard_scoreboard #(
        .NUM_PENDING (2),
        .REG_AW      (5),
        .TIMEOUT     (8)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .dec_valid         (dec_valid),
        .dec_inst          (dec_inst),
        .wb_valid          (wb_valid),
        .wb_rd             (wb_rd),
        .flush             (flush),
        .stall             (stall),
        .pending_cnt       (pending_cnt),
`ifdef HAZARD_STATS_EN
        .stat_stall_cycles (stat_stall_cycles),
        .stat_raw_stalls   (stat_raw_stalls),
`endif
        .timeout_err       (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        dv;
        logic [31:0] inst;
        logic        wv;
        logic [4:0]  wrd;
        logic        fl;
        logic        exp_stall;
        logic [1:0]  exp_cnt;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] f_lw(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b010, rd, 7'b0000011};
    endfunction
    function automatic logic [31:0] f_add(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] f_addi(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd1, rs1, 3'b000, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] f_sw(input logic [4:0] rs2, input logic [4:0] rs1);
        return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
    endfunction
    function automatic logic [31:0] f_lui(input logic [4:0] rd);
        return {20'h12345, rd, 7'b0110111};
    endfunction

    function automatic vec_t mk(input logic dv, input logic [31:0] inst, input logic wv,
                                input logic [4:0] wrd, input logic fl, input logic st,
                                input logic [1:0] cnt, input logic err);
        vec_t v;
        v.dv = dv; v.inst = inst; v.wv = wv; v.wrd = wrd; v.fl = fl;
        v.exp_stall = st; v.exp_cnt = cnt; v.exp_err = err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        // Load-use: issue x5, reader waits 3 cycles, wb on the third.
        vecs.push_back(mk(1, f_lw(5, 0),     0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, f_add(6, 5, 1), 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1, f_add(6, 5, 1), 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1, f_add(6, 5, 1), 1, 5, 0, 1, 1, 0));
        vecs.push_back(mk(1, f_add(6, 5, 1), 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 32'd0,          0, 0, 0, 0, 0, 0));
        // Full table; slot freed by wb x3 is reused only the next cycle.
        vecs.push_back(mk(1, f_lw(3, 0),     0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, f_lw(4, 0),     0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, f_lw(7, 0),     0, 0, 0, 1, 2, 0));
        vecs.push_back(mk(1, f_lw(7, 0),     1, 3, 0, 1, 2, 0));
        vecs.push_back(mk(1, f_lw(7, 0),     0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 32'd0,          1, 4, 0, 0, 2, 0));
        vecs.push_back(mk(0, 32'd0,          1, 7, 0, 0, 1, 0));
        vecs.push_back(mk(0, 32'd0,          0, 0, 0, 0, 0, 0));
        // x0 is never tracked nor a hazard.
        vecs.push_back(mk(1, f_lw(0, 0),     0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, f_add(1, 0, 0), 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 32'd0,          0, 0, 0, 0, 0, 0));
        // Flush squashes x9; late wb ignored; load issued under flush not tracked.
        vecs.push_back(mk(1, f_lw(9, 0),      0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, f_add(10, 9, 0), 0, 0, 1, 0, 1, 0));
        vecs.push_back(mk(1, f_add(10, 9, 0), 1, 9, 0, 0, 0, 0));
        vecs.push_back(mk(1, f_lw(11, 0),     0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 32'd0,           0, 0, 0, 0, 0, 0));
        // Simultaneous alloc x8 / clear x5; LUI no hazard; WAW; store rs2 hazard.
        vecs.push_back(mk(1, f_lw(5, 0),     0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 32'd0,          0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, f_lw(8, 0),     1, 5, 0, 0, 1, 0));
        vecs.push_back(mk(1, f_lui(8),       0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, f_lw(8, 0),     0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1, f_sw(8, 0),     1, 8, 0, 1, 1, 0));
        vecs.push_back(mk(1, f_sw(8, 0),     0, 0, 0, 0, 0, 0));
        // Timeout: x2 never returns, reader held for 8 stall cycles.
        vecs.push_back(mk(1, f_lw(2, 0),     0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 8; k++) vecs.push_back(mk(1, f_addi(1, 2), 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1, f_addi(1, 2),   0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, f_addi(1, 2),   0, 0, 0, 0, 0, 1));

        // Reset state, with a would-be instruction at decode.
        rst_n     = 1'b0;
        dec_valid = 1'b1;
        dec_inst  = f_add(1, 2, 3);
        wb_valid  = 1'b0;
        wb_rd     = 5'd0;
        flush     = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset stall", {31'd0, stall}, 32'd0);
        check("reset pending_cnt", {30'd0, pending_cnt}, 32'd0);
        check("reset timeout_err", {31'd0, timeout_err}, 32'd0);
        rst_n     = 1'b1;
        dec_valid = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            dec_valid = vecs[i].dv;
            dec_inst  = vecs[i].inst;
            wb_valid  = vecs[i].wv;
            wb_rd     = vecs[i].wrd;
            flush     = vecs[i].fl;
            #1;
            check($sformatf("v%0d stall", i), {31'd0, stall}, {31'd0, vecs[i].exp_stall});
            check($sformatf("v%0d pending_cnt", i), {30'd0, pending_cnt},
                  {30'd0, vecs[i].exp_cnt});
            check($sformatf("v%0d timeout_err", i), {31'd0, timeout_err},
                  {31'd0, vecs[i].exp_err});
        end

        @(negedge clk);
`ifdef HAZARD_STATS_EN
        check("stat_stall_cycles", stat_stall_cycles, 32'd15);
        check("stat_raw_stalls", stat_raw_stalls, 32'd2);
`endif
        // Reset forces stall low and clears the sticky error.
        rst_n     = 1'b0;
        dec_valid = 1'b1;
        dec_inst  = f_addi(1, 2);
        wb_valid  = 1'b0;
        flush     = 1'b0;
        #1;
        check("in-reset stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        #1;
        check("post-reset timeout_err", {31'd0, timeout_err}, 32'd0);
        check("post-reset pending_cnt", {30'd0, pending_cnt}, 32'd0);
`ifdef HAZARD_STATS_EN
        check("post-reset stat_stall_cycles", stat_stall_cycles, 32'd0);
        check("post-reset stat_raw_stalls", stat_raw_stalls, 32'd0);
`endif
        rst_n     = 1'b1;
        dec_valid = 1'b0;
        @(negedge clk);
        #1;
        check("released timeout_err", {31'd0, timeout_err}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
